// File: rtl/seq_alu_if.sv
// Control-unit to ALU bus: operands and opcode in, registered results and status out.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       select;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             done;
  logic             busy;
  logic             zero;
  logic             negative;
  logic             div_by_zero;

  modport master (
    output start, select, A, B,
    input  result_lo, result_hi, done, busy, zero, negative, div_by_zero
  );

  modport slave (
    input  start, select, A, B,
    output result_lo, result_hi, done, busy, zero, negative, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/arith/shift ops plus iterative signed
// Booth multiply and restoring divide sharing one accumulator datapath.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic      clock,
  input logic      clear,
  seq_alu_if.slave bus
);
  localparam int CW = SHW + 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;
  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000, OP_SUB = 5'b00001, OP_AND = 5'b00010, OP_OR  = 5'b00011,
    OP_SHL  = 5'b00100, OP_NOT = 5'b00101, OP_SHRA = 5'b00110, OP_SHR = 5'b00111,
    OP_ROL  = 5'b01000, OP_ROR = 5'b01001, OP_NEG = 5'b01010, OP_MUL = 5'b01011,
    OP_DIV  = 5'b01100
  } op_e;

  state_e           state, state_n;
  logic [WIDTH:0]   acc, m;
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res, a_abs, b_abs;
  logic [WIDTH:0]   b_sum, acc_b, d_shift, d_trial, acc_d;
  logic [WIDTH-1:0] q_b, q_d, q_fix, r_fix;

  logic             ld_mul, ld_div, out_we, hi_sign, dbz_n;
  logic [WIDTH-1:0] lo_n, hi_n;

  assign sh    = bus.B[SHW-1:0];
  assign a_abs = bus.A[WIDTH-1] ? -bus.A : bus.A;
  assign b_abs = bus.B[WIDTH-1] ? -bus.B : bus.B;
  assign q_fix = neg_q ? -q : q;
  assign r_fix = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign bus.busy = (state != S_IDLE);

  always_comb begin
    alu_res = '0;
    case (bus.select)
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_SUB:  alu_res = bus.A - bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_SHL:  alu_res = bus.A << sh;
      OP_NOT:  alu_res = ~bus.A;
      OP_SHRA: alu_res = $signed(bus.A) >>> sh;
      OP_SHR:  alu_res = bus.A >> sh;
      // A shift by WIDTH yields 0, so amount 0 needs no special case.
      OP_ROL:  alu_res = (bus.A << sh) | (bus.A >> (WIDTH - int'(sh)));
      OP_ROR:  alu_res = (bus.A >> sh) | (bus.A << (WIDTH - int'(sh)));
      OP_NEG:  alu_res = -bus.A;
      default: alu_res = '0;
    endcase
  end

  // One Booth step followed by an arithmetic shift of {acc, q, q_1}.
  always_comb begin
    case ({q[0], q_1})
      2'b01:   b_sum = acc + m;
      2'b10:   b_sum = acc - m;
      default: b_sum = acc;
    endcase
    acc_b = {b_sum[WIDTH], b_sum[WIDTH:1]};
    q_b   = {b_sum[0], q[WIDTH-1:1]};
  end

  // One restoring-division step: remainder in acc, dividend shifts out of q.
  always_comb begin
    d_shift = {acc[WIDTH-1:0], q[WIDTH-1]};
    d_trial = d_shift - m;
    if (d_trial[WIDTH]) begin
      acc_d = d_shift;
      q_d   = {q[WIDTH-2:0], 1'b0};
    end else begin
      acc_d = d_trial;
      q_d   = {q[WIDTH-2:0], 1'b1};
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    ld_mul  = 1'b0;
    ld_div  = 1'b0;
    out_we  = 1'b0;
    hi_sign = 1'b0;
    dbz_n   = 1'b0;
    lo_n    = '0;
    hi_n    = '0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.select == OP_MUL) begin
            ld_mul  = 1'b1;
            state_n = S_MUL;
          end else if (bus.select == OP_DIV) begin
            if (bus.B == '0) begin
              out_we  = 1'b1;
              lo_n    = '1;
              hi_n    = bus.A;
              hi_sign = 1'b1;
              dbz_n   = 1'b1;
            end else begin
              ld_div  = 1'b1;
              state_n = S_DIV;
            end
          end else begin
            out_we = 1'b1;
            lo_n   = alu_res;
          end
        end
      end
      S_MUL: begin
        if (cnt == CW'(1)) begin
          out_we  = 1'b1;
          lo_n    = q_b;
          hi_n    = acc_b[WIDTH-1:0];
          hi_sign = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_DIV: begin
        if (cnt == CW'(1)) state_n = S_FIX;
      end
      S_FIX: begin
        out_we  = 1'b1;
        lo_n    = q_fix;
        hi_n    = r_fix;
        hi_sign = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (ld_mul) begin
      acc <= '0;
      m   <= {bus.A[WIDTH-1], bus.A};
      q   <= bus.B;
      q_1 <= 1'b0;
      cnt <= CW'(WIDTH);
    end else if (ld_div) begin
      acc   <= '0;
      m     <= {1'b0, b_abs};
      q     <= a_abs;
      q_1   <= 1'b0;
      cnt   <= CW'(WIDTH);
      neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
      neg_r <= bus.A[WIDTH-1];
    end else if (state == S_MUL) begin
      acc <= acc_b;
      q   <= q_b;
      q_1 <= q[0];
      cnt <= cnt - 1'b1;
    end else if (state == S_DIV) begin
      acc <= acc_d;
      q   <= q_d;
      cnt <= cnt - 1'b1;
    end
  end

  // Architectural outputs change only on completion.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      bus.result_lo   <= '0;
      bus.result_hi   <= '0;
      bus.done        <= 1'b0;
      bus.zero        <= 1'b0;
      bus.negative    <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= out_we;
      if (out_we) begin
        bus.result_lo   <= lo_n;
        bus.result_hi   <= hi_n;
        bus.zero        <= ({hi_n, lo_n} == '0);
        bus.negative    <= hi_sign ? hi_n[WIDTH-1] : lo_n[WIDTH-1];
        bus.div_by_zero <= dbz_n;
      end
    end
  end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath's combinational ALU.
- Keeps the existing select encodings for ADD/SUB/AND/OR/SHL/SHR/NOT and adds arithmetic shift, rotates, negate, signed multiply and signed divide.
- Multiply and divide are iterative multi-cycle operations producing a 2*WIDTH result split into HI/LO.
- Sits between the register-file operand latches and the Z/HI/LO registers; the control unit drives it through a start/done handshake.

Parameters:
- WIDTH, 32: operand and half-result width; must be a power of 2, 8 or more.
- SHW, $clog2(WIDTH): shift/rotate amount width, derived; do not override.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  reset, asynchronous and active-high.
- start  input  1  launch operation; sampled only when busy=0.
- select  input  5  opcode.
- A  input  WIDTH  operand A; for DIV, the dividend.
- B  input  WIDTH  operand B; for DIV, the divisor; low SHW bits give the shift amount.
- result_lo  output  WIDTH  result, or product low half, or quotient.
- result_hi  output  WIDTH  product high half, or remainder; 0 for non-MUL/DIV ops.
- done  output  1  one-cycle completion pulse.
- busy  output  1  multi-cycle op in progress.
- zero  output  1  {result_hi,result_lo}==0, updated with done.
- negative  output  1  MSB of the result (result_hi MSB for MUL/DIV, else result_lo MSB), updated with done.
- div_by_zero  output  1  last completed op was DIV with B==0.

Behaviour:
- Opcodes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SHL, 00111 SHR (logical), 00101 NOT A.
  - 00110 SHRA, 01000 ROL, 01001 ROR, 01010 NEG (0-A), 01011 MUL (signed), 01100 DIV (signed).
  - Any other code: result 0, latency 1.
- Operand capture: A, B and select are captured on the start edge and may change afterwards.
- Shifts and rotates use B[SHW-1:0] only, i.e. the amount modulo WIDTH.
- ADD/SUB/NEG wrap modulo 2^WIDTH; no carry or overflow output.
- States: IDLE, MUL, DIV, FIX.
  - IDLE: on start, single-cycle ops (and DIV with B==0) register their result; done=1 in the next cycle; stay in IDLE.
  - MUL: load {A, B}, counter=WIDTH, go to MUL. Radix-2 Booth uses a WIDTH+1-bit accumulator and arithmetic-shifts once per cycle. After WIDTH iterations, write the 2*WIDTH product, pulse done, return to IDLE.
  - DIV (B!=0): load |A| and |B|, record both signs, go to DIV. Unsigned restoring division runs one quotient bit per cycle for WIDTH cycles, then goes to FIX.
  - FIX: negate the quotient if the signs differ; give the remainder the sign of the dividend; write outputs, pulse done, return to IDLE.
- Latency, counted in edges from the start-sampling edge to the edge after which done=1:
  - single-cycle ops: 1.
  - MUL: WIDTH+1.
  - DIV: WIDTH+2.
  - DIV by zero: 1.
- Divide by zero: result_lo = all ones, result_hi = A, div_by_zero=1.
  - div_by_zero is cleared by the next completed op.
- Most-negative dividend divided by -1 gives quotient 0x80..0 and remainder 0, the natural wrap; no flag.
- busy is 1 from the cycle after a MUL/DIV start until the cycle in which done=1 (inclusive of the FIX state); busy=0 when done=1.
- start while busy=1 is ignored; the in-flight op is unaffected.
- start in the same cycle that done=1 is accepted (busy=0 then).
- Result outputs and flags hold their values until the next completion; intermediate iteration values never appear on result_hi/result_lo.
- clear at any time, including mid-MUL or mid-DIV, asynchronously forces:
  - state IDLE and counter 0;
  - result_lo, result_hi, done, busy, zero, negative, div_by_zero all 0.
- The first start after clear deasserts behaves normally.

Test Plan:
- ADD wrap: A=0xFFFFFFFF, B=1 -> result_lo=0x00000000, zero=1, done one cycle after start.
- Shifts and rotates:
  - ROR A=0x00000001, B=1 -> 0x80000000.
  - B=33 -> 0x80000000 (amount is modulo 32).
  - SHRA A=0x80000000, B=4 -> 0xF8000000.
- MUL A=0xFFFFFFF9 (-7), B=6:
  - busy high, done exactly 33 edges after start;
  - result_hi=0xFFFFFFFF, result_lo=0xFFFFFFD6, negative=1.
  - A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0.
- DIV A=0xFFFFFFEF (-17), B=5:
  - done 34 edges after start;
  - result_lo=0xFFFFFFFD (-3), result_hi=0xFFFFFFFE (-2).
  - A=10, B=0 -> done after 1 edge, div_by_zero=1, lo=0xFFFFFFFF, hi=0x0000000A.
- Start during busy: a second start (ADD) is issued 5 cycles into a MUL -> ignored; only one done pulse, carrying the MUL result.
- Reset mid-operation: assert clear asynchronously 10 cycles into a DIV -> all outputs 0 immediately, no done. A following ADD 2+3 -> result_lo=5.
